// File: rtl/mesm6_membus.sv
// mesm6_membus: arbitrates the MESM-6 ibus/dbus onto one single-port 48-bit memory; word 0 reads as zero.
// Optional one-entry instruction word buffer enabled by defining MESM6_IBUF_EN.
module mesm6_membus #(
  parameter int AW = 15,
  parameter int DW = 48
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ibus_fetch,
  input  logic [AW-1:0] ibus_addr,
  output logic [DW-1:0] ibus_input,
  output logic          ibus_done,
  input  logic          dbus_read,
  input  logic          dbus_write,
  input  logic [AW-1:0] dbus_addr,
  input  logic [DW-1:0] dbus_output,
  output logic [DW-1:0] dbus_input,
  output logic          dbus_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic port_q, port_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d, ibus_input_q, ibus_input_d, dbus_input_q, dbus_input_d;
  logic ibus_done_q, ibus_done_d, dbus_done_q, dbus_done_d;
  logic dsel, hit, fin;
  logic [AW-1:0] addr;
  logic [DW-1:0] rsp, buf_data;
  assign dsel = dbus_read | dbus_write;
  assign addr = dsel ? dbus_addr : ibus_addr;
`ifdef MESM6_IBUF_EN
  logic [AW-1:0] tag_q, tag_d;
  logic bvalid_q, bvalid_d;
  logic [DW-1:0] bdata_q, bdata_d;
  assign hit = !dsel && ibus_fetch && bvalid_q && tag_q == ibus_addr;
  assign buf_data = bdata_q;
  always_ff @(posedge clk)
    if (reset) begin
      tag_q <= '0;
      bvalid_q <= 1'b0;
      bdata_q <= '0;
    end else begin
      tag_q <= tag_d;
      bvalid_q <= bvalid_d;
      bdata_q <= bdata_d;
    end
`else
  assign hit = 1'b0;
  assign buf_data = '0;
`endif
  always_comb begin
    state_d = state_q;
    port_d = port_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ibus_input_d = ibus_input_q;
    dbus_input_d = dbus_input_q;
    ibus_done_d = 1'b0;
    dbus_done_d = 1'b0;
    rsp = '0;
    fin = 1'b0;
`ifdef MESM6_IBUF_EN
    tag_d = tag_q;
    bvalid_d = bvalid_q;
    bdata_d = bdata_q;
`endif
    case (state_q)
      IDLE: if (dsel || ibus_fetch) begin
        port_d = dsel;
        mem_we_d = dbus_write;
        mem_addr_d = addr;
        mem_wdata_d = dbus_output;
        // word 0 and buffer hits complete without a memory cycle
        fin = addr == '0 || hit;
        rsp = dsel && dbus_write ? dbus_output : hit ? buf_data : '0;
        mem_req_d = !fin;
        state_d = fin ? RESP : ACCESS;
      end
      ACCESS: if (mem_ack) begin
        fin = 1'b1;
        rsp = mem_we_q ? mem_wdata_q : mem_rdata;
        mem_req_d = 1'b0;
        state_d = RESP;
`ifdef MESM6_IBUF_EN
        if (!port_q) begin
          tag_d = mem_addr_q;
          bvalid_d = 1'b1;
          bdata_d = mem_rdata;
        end
`endif
      end
      default: begin
        state_d = IDLE;
`ifdef MESM6_IBUF_EN
        if (port_q && mem_we_q && mem_addr_q == tag_q) bvalid_d = 1'b0;
`endif
      end
    endcase
    if (fin) begin
      ibus_done_d = !port_d;
      dbus_done_d = port_d;
      ibus_input_d = port_d ? ibus_input_q : rsp;
      dbus_input_d = port_d ? rsp : dbus_input_q;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      port_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      ibus_input_q <= '0;
      dbus_input_q <= '0;
      ibus_done_q <= 1'b0;
      dbus_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q <= port_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ibus_input_q <= ibus_input_d;
      dbus_input_q <= dbus_input_d;
      ibus_done_q <= ibus_done_d;
      dbus_done_q <= dbus_done_d;
    end
  assign mem_req = mem_req_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ibus_input = ibus_input_q;
  assign dbus_input = dbus_input_q;
  assign ibus_done = ibus_done_q;
  assign dbus_done = dbus_done_q;
endmodule

// File: tb/tb_mesm6_membus.sv
// tb_mesm6_membus: scoreboard bench for mesm6_membus with a word-level memory and core-visible reference.
`timescale 1ns/1ps
module tb_mesm6_membus;
  localparam int AW = 15;
  localparam int DW = 48;
  logic clk = 1'b0, reset = 1'b1;
  logic ibus_fetch = 1'b0, dbus_read = 1'b0, dbus_write = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] ibus_addr = '0, dbus_addr = '0;
  logic [DW-1:0] dbus_output = '0, mem_rdata = '0;
  logic [DW-1:0] ibus_input, dbus_input, mem_wdata;
  logic ibus_done, dbus_done, mem_req, mem_we;
  logic [AW-1:0] mem_addr, acc_addr;
  int checks = 0, failures = 0;
  logic [DW-1:0] mem [0:127];
  logic [DW-1:0] ref_mem [0:127];
  logic [DW-1:0] iq[$], dq[$];
  bit we_log[$];
  int req_cnt = 0, fixed_wait = -1, wcnt = 0;
  bit hold = 1'b0, stray = 1'b0, busy = 1'b0;

  mesm6_membus dut (
    .clk(clk), .reset(reset),
    .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr), .ibus_input(ibus_input), .ibus_done(ibus_done),
    .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_addr(dbus_addr), .dbus_output(dbus_output),
    .dbus_input(dbus_input), .dbus_done(dbus_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory: accepts a request, waits, acks once; stray pulses an ack with no request pending.
  always @(posedge clk) begin
    #1;
    mem_ack = 1'b0;
    if (reset) busy = 1'b0;
    else if (stray) begin
      mem_ack = 1'b1;
      mem_rdata = '1;
    end else begin
      if (mem_req && !busy) begin
        busy = 1'b1;
        req_cnt++;
        we_log.push_back(mem_we);
        acc_addr = mem_addr;
        wcnt = fixed_wait >= 0 ? fixed_wait : int'($urandom_range(0, 2));
      end
      if (busy && !hold) begin
        if (wcnt == 0) begin
          chki("mem_addr_stable", int'(mem_addr), int'(acc_addr));
          if (mem_we) mem[mem_addr[6:0]] = mem_wdata;
          mem_rdata = mem[mem_addr[6:0]];
          mem_ack = 1'b1;
          busy = 1'b0;
        end else wcnt--;
      end
    end
  end

  always @(negedge clk)
    if (!reset) begin
      if (dbus_done) begin
        if (dq.size() == 0) chki("dbus_done_unexpected", 1, 0);
        else chk("dbus_data", dbus_input, dq.pop_front());
      end
      if (ibus_done) begin
        if (iq.size() == 0) chki("ibus_done_unexpected", 1, 0);
        else chk("ibus_data", ibus_input, iq.pop_front());
      end
    end

  task automatic op(input bit fi, input logic [AW-1:0] ia, input bit rd, input bit wr,
                    input logic [AW-1:0] da, input logic [DW-1:0] wd, output int lat_d, output int lat_i);
    bit pd, pi;
    pd = rd | wr;
    pi = fi;
    lat_d = 0;
    lat_i = 0;
    if (pd) begin
      dq.push_back(wr ? wd : (da == '0) ? '0 : ref_mem[da[6:0]]);
      if (wr && da != '0) ref_mem[da[6:0]] = wd;
    end
    if (pi) iq.push_back((ia == '0) ? '0 : ref_mem[ia[6:0]]);
    @(posedge clk);
    #1;
    ibus_fetch = fi; ibus_addr = ia;
    dbus_read = rd; dbus_write = wr; dbus_addr = da; dbus_output = wd;
    for (int n = 1; n <= 60 && (pd || pi); n++) begin
      @(posedge clk);
      #1;
      if (pd && dbus_done) begin pd = 0; lat_d = n; dbus_read = 1'b0; dbus_write = 1'b0; end
      if (pi && ibus_done) begin pi = 0; lat_i = n; ibus_fetch = 1'b0; end
    end
    if (pd || pi) chki("op_timeout", 1, 0);
  endtask

  initial begin
    int ld, li, r0, n0, k;
    logic [63:0] v;
    logic [DW-1:0] nd;
    for (int i = 0; i < 128; i++) begin
      v = {$urandom(), $urandom()};
      mem[i] = v[DW-1:0];
      ref_mem[i] = v[DW-1:0];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chki("rst_mem_req", int'(mem_req), 0);
    chki("rst_mem_we", int'(mem_we), 0);
    chki("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chki("rst_ibus_done", int'(ibus_done), 0);
    chki("rst_dbus_done", int'(dbus_done), 0);
    chk("rst_ibus_input", ibus_input, '0);
    chk("rst_dbus_input", dbus_input, '0);
    reset = 1'b0;

    mem[83] = 48'h123456789ABC;
    ref_mem[83] = 48'h123456789ABC;
    fixed_wait = 2;
    op(0, '0, 1, 0, 15'o00123, '0, ld, li);
    chki("read_latency", ld, 4);
    chk("read_value", dbus_input, 48'h123456789ABC);

    fixed_wait = -1;
    n0 = we_log.size();
    op(1, 15'd5, 0, 1, 15'd5, 48'hFFFF00000001, ld, li);
    chki("wf_first_is_write", int'(we_log[n0]), 1);
    chki("wf_second_is_read", int'(we_log[n0+1]), 0);
    chk("wf_fetch_value", ibus_input, 48'hFFFF00000001);

    r0 = req_cnt;
    op(0, '0, 0, 1, '0, 48'hABCDEF012345, ld, li);
    chki("zero_write_latency", ld, 1);
    op(0, '0, 1, 0, '0, '0, ld, li);
    chki("zero_read_latency", ld, 1);
    chk("zero_read_value", dbus_input, '0);
    chki("zero_no_mem_req", req_cnt, r0);

    hold = 1'b1;
    @(posedge clk);
    #1;
    dbus_read = 1'b1; dbus_addr = 15'd3;
    k = 0;
    while (!mem_req && k < 10) begin @(posedge clk); #1; k++; end
    chki("rst_mid_req_raised", int'(mem_req), 1);
    reset = 1'b1; dbus_read = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; hold = 1'b0;
    chki("rst_mid_mem_req", int'(mem_req), 0);
    chki("rst_mid_dbus_done", int'(dbus_done), 0);
    #1 stray = 1'b1;
    @(posedge clk);
    #2 stray = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chki("stray_ack_mem_req", int'(mem_req), 0);
      chki("stray_ack_done", int'(dbus_done | ibus_done), 0);
    end

    fixed_wait = 1;
    op(1, 15'o100, 0, 0, '0, '0, ld, li);
    chki("ibuf_first_latency", li, 3);
    r0 = req_cnt;
    op(1, 15'o100, 0, 0, '0, '0, ld, li);
`ifdef MESM6_IBUF_EN
    chki("ibuf_hit_latency", li, 1);
    chki("ibuf_hit_no_req", req_cnt, r0);
`else
    chki("nobuf_refetch_latency", li, 3);
    chki("nobuf_refetch_req", req_cnt, r0 + 1);
`endif
    v = {$urandom(), $urandom()};
    nd = v[DW-1:0];
    op(0, '0, 0, 1, 15'o100, nd, ld, li);
    r0 = req_cnt;
    op(1, 15'o100, 0, 0, '0, '0, ld, li);
    chki("ibuf_inval_latency", li, 3);
    chki("ibuf_inval_req", req_cnt, r0 + 1);
    chk("ibuf_inval_value", ibus_input, nd);

    fixed_wait = -1;
    for (int t = 0; t < 250; t++) begin
      logic [AW-1:0] ia, da;
      v = {$urandom(), $urandom()};
      ia = AW'($urandom_range(0, 7));
      da = AW'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: op(1, ia, 0, 0, da, v[DW-1:0], ld, li);
        1: op(0, ia, 1, 0, da, v[DW-1:0], ld, li);
        2: op(0, ia, 0, 1, da, v[DW-1:0], ld, li);
        3: op(0, ia, 1, 1, da, v[DW-1:0], ld, li);
        4: op(1, ia, 0, 1, da, v[DW-1:0], ld, li);
        default: op(1, ia, 1, 0, da, v[DW-1:0], ld, li);
      endcase
    end
    repeat (4) @(posedge clk);
    chki("dq_drained", dq.size(), 0);
    chki("iq_drained", iq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
